// File: rtl/divide_pkg.sv
// Shared types and sizing helpers for the iterative restoring divider.
// Contents: state_e FSM encoding, n_iter() clocks per divide, cnt_width()
// width of the BUSY clock counter.
package divide_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of BUSY clocks for a full-length divide.
  function automatic int unsigned n_iter(input int unsigned width,
                                         input int unsigned bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Counter width able to hold 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divide_step.sv
// Combinational restoring-divide step: performs BITS_PER_CYCLE
// quotient-bit decisions, MSB first.
// Ports:
//   r_i    partial remainder in (WIDTH+1 bits)
//   den_i  divisor
//   quot_i quotient so far; new bits are shifted in at the LSB
//   r_o    partial remainder out
//   quot_o quotient out
module divide_step #(
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] den_i,
  input  logic [WIDTH-1:0] quot_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0]   r_c;
  logic [WIDTH-1:0] q_c;
  logic [WIDTH+1:0] t_c;

  // t = 2r - den; the top bit of the extended difference is the borrow.
  always_comb begin
    r_c = r_i;
    q_c = quot_i;
    t_c = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      t_c = {r_c, 1'b0} - {2'b00, den_i};
      if (!t_c[WIDTH+1]) begin
        r_c = t_c[WIDTH:0];
        q_c = {q_c[WIDTH-2:0], 1'b1};
      end else begin
        r_c = {r_c[WIDTH-1:0], 1'b0};
        q_c = {q_c[WIDTH-2:0], 1'b0};
      end
    end
    r_o    = r_c;
    quot_o = q_c;
  end

endmodule

// File: rtl/divide_iter.sv
// Iterative handshaked restoring fraction divider: quot/rem of num/den with
// num <= den, BITS_PER_CYCLE quotient bits retired per BUSY clock.
// Optional feature macro: DIVIDE_EARLY_TERM_EN (finish as soon as the partial
// remainder reaches zero; results unchanged, latency shorter).
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   num, den            dividend and divisor fractions
//   out_valid/out_ready result handshake (result held until consumed)
//   quot, rem           quotient and final partial remainder
//   sticky              rem != 0
//   dz                  divide by zero
module divide_iter
  import divide_pkg::*;
#(
  parameter int unsigned WIDTH          = 26,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             sticky,
  output logic             dz
);

  localparam int unsigned N_ITER = n_iter(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CNT_W  = cnt_width(N_ITER);

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH:0]   step_r_c;
  logic [WIDTH-1:0] step_quot_c;

  divide_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .r_i    (r_q),
    .den_i  (den_q),
    .quot_i (quot_q),
    .r_o    (step_r_c),
    .quot_o (step_quot_c)
  );

`ifdef DIVIDE_EARLY_TERM_EN
  // Left shift that pads the quotient bits not yet produced with zeros.
  logic [31:0] shamt_c;
  always_comb begin
    shamt_c = (32'(N_ITER) - 32'd1 - 32'(cnt_q)) * 32'(BITS_PER_CYCLE);
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    den_d    = den_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d   = {1'b0, num};
          den_d = den;
          cnt_d = '0;
          dz_d  = (den == '0);
          // Divide by zero spends one BUSY clock without stepping so its
          // result appears one edge after accept.
          quot_d  = (den == '0) ? '1 : '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (dz_q) begin
          state_d = DONE;
        end else begin
          r_d    = step_r_c;
          quot_d = step_quot_c;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_ITER - 1)) begin
            state_d = DONE;
          end
`ifdef DIVIDE_EARLY_TERM_EN
          else if (step_r_c == '0) begin
            state_d = DONE;
            quot_d  = step_quot_c << shamt_c;
          end
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sticky_d    = |r_d[WIDTH-1:0];
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      den_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      den_q       <= den_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = r_q[WIDTH-1:0];
  assign sticky    = sticky_q;
  assign dz        = dz_q;

endmodule

// File: doc/divide_iter.md
# divide_iter

Iterative, handshaked successor of the fixed-pipeline restoring fraction divider. It computes the WIDTH-bit fixed-point quotient and remainder of num/den, retiring BITS_PER_CYCLE quotient bits per clock. It uses one reusable step datapath instead of a pipeline. It sits in the FPU mantissa divide path, between operand alignment and rounding, and supplies quotient, remainder and sticky to the rounder.

## Interface
- WIDTH, 26: operand, quotient and remainder width; must be ≥ 2.
- BITS_PER_CYCLE, 2: restoring steps per clock; must divide WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- num  in  WIDTH  dividend, unsigned fraction; precondition num ≤ den when den ≠ 0.
- den  in  WIDTH  divisor, unsigned fraction.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  downstream accepts result.
- quot  out  WIDTH  quotient.
- rem  out  WIDTH  final partial remainder.
- sticky  out  1  rem ≠ 0.
- dz  out  1  divide by zero (den = 0).

## Operation
- N_ITER = WIDTH/BITS_PER_CYCLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch num into the partial remainder (WIDTH+1 bits), latch den, clear quot and the iteration counter.
  - If den=0: go to DONE with dz=1, quot=all ones, rem=num.
  - Otherwise go to BUSY.
- BUSY:
  - Each clock performs BITS_PER_CYCLE restoring steps, MSB first: t = 2r − den. If t ≥ 0 (bit WIDTH clear), q bit = 1 and r = t. Otherwise q bit = 0 and r = 2r (restore).
  - The counter increments; after N_ITER clocks, go to DONE.
- DONE:
  - out_valid=1, outputs stable.
  - On out_ready, go to IDLE.
  - in_ready=0, so there is no overlap between a held result and a new accept.
- Result identity for den ≠ 0: num·2^WIDTH = quot·den + rem, 0 ≤ rem ≤ den.
  - num < den: quot = floor(num·2^WIDTH/den).
  - num = den: quot = 2^WIDTH−1, rem = den.
- sticky = |rem in all cases, including dz.
- num > den with den ≠ 0 violates the precondition; the result is undefined but the FSM must still complete and return to IDLE.
- Reset values: in_ready=1 (state IDLE); out_valid=0; quot=0; rem=0; sticky=0; dz=0.
- Reset mid-operation aborts immediately. No out_valid follows, and the next accept behaves as after power-up.
- in_valid while not in IDLE is ignored: no accept and no side effects.

## Timing
- Accept edge E0 occurs when in_valid & in_ready.
- Normal latency: out_valid rises after edge E0+N_ITER.
- Divide by zero: out_valid rises after edge E0+1.
- out_valid & out_ready at edge Ed returns the block to IDLE; in_ready=1 after Ed.
- Throughput: one operation per N_ITER+2 cycles with out_ready held high.
- Outputs are registered. No combinational path from in_valid/out_ready to any output except through the state register.

## Configuration
- DIVIDE_EARLY_TERM_EN.
- Defined: after any BUSY clock, if the updated partial remainder is zero, go to DONE at that edge. The remaining low quotient bits are zero and latency becomes k clocks (1 ≤ k ≤ N_ITER).
- Undefined: always N_ITER BUSY clocks.
- Results are bit-identical in both builds; only latency differs.

## Structure
- Package divide_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - helper function computing N_ITER and the counter width $clog2(N_ITER+1).
- Sub-module divide_step: purely combinational. It takes r, den and the quotient-in, performs BITS_PER_CYCLE restoring steps, and returns r-out and quot-out. One instance, driven by the FSM registers.

## Test plan
All with WIDTH=8, BITS_PER_CYCLE=2 (N_ITER=4).
- num=0x01, den=0x03 → quot=0x55, rem=0x01, sticky=1, dz=0; out_valid rises 4 edges after accept.
- num=0x40, den=0x80 → quot=0x80, rem=0x00, sticky=0.
  - Latency is 4 edges without DIVIDE_EARLY_TERM_EN.
  - Latency is 1 edge with it.
- num=den=0x80 → quot=0xFF, rem=0x80, sticky=1.
- den=0x00, num=0x05 → dz=1, quot=0xFF, rem=0x05, sticky=1; out_valid after 1 edge.
- Backpressure:
  - Hold out_ready=0 for 10 cycles with in_valid held high and different operands presented.
  - Outputs stay stable and in_ready=0 throughout.
  - After out_ready=1 for one edge, the new operands are accepted on the following edge.
- Assert rst during BUSY cycle 2:
  - All outputs return to their reset values asynchronously.
  - out_valid never pulses.
  - A subsequent 0x01/0x03 divide returns 0x55.
